display_arbiter: RTL and testbench

//   Shares the single seven_seg_fsm display between three requesters: 0 = keypad entry,
//   1 = computed result, 2 = status/error. Fixed priority, 2 highest. Sits directly in

---
 rtl/display_arbiter_if.sv | 38 +++
 rtl/display_arbiter.sv | 139 +++++++++++++
 tb/tb_display_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/display_arbiter_if.sv
// Bundle between the three display requesters and the display arbiter.
// master: requester side, drives req/num*/mode* and observes grant and display outputs.
// slave:  arbiter side, observes requests and drives grant and display outputs.
//   req          per-requester level request (0 = keypad, 1 = result, 2 = status)
//   num0/1/2     value offered by each requester
//   mode0/1/2    display mode offered by each requester
//   grant        one-hot current owner, 0 when idle
//   disp_valid   display content valid
//   disp_number  value towards seven_seg_fsm input_number
//   disp_mode    mode towards seven_seg_fsm mode
//   disp_ovf     disp_number exceeds the 8-digit range
interface display_arbiter_if #(
   parameter int unsigned NUM_W  = 39,
   parameter int unsigned MODE_W = 2
);
   logic [2:0]        req;
   logic [NUM_W-1:0]  num0;
   logic [NUM_W-1:0]  num1;
   logic [NUM_W-1:0]  num2;
   logic [MODE_W-1:0] mode0;
   logic [MODE_W-1:0] mode1;
   logic [MODE_W-1:0] mode2;
   logic [2:0]        grant;
   logic              disp_valid;
   logic [NUM_W-1:0]  disp_number;
   logic [MODE_W-1:0] disp_mode;
   logic              disp_ovf;

   modport master (
      output req, num0, num1, num2, mode0, mode1, mode2,
      input  grant, disp_valid, disp_number, disp_mode, disp_ovf
   );

   modport slave (
      input  req, num0, num1, num2, mode0, mode1, mode2,
      output grant, disp_valid, disp_number, disp_mode, disp_ovf
   );
endinterface

// File: rtl/display_arbiter.sv
// Fixed-priority arbiter sharing one seven_seg_fsm between three requesters
// (index 2 highest). Keeps the owner on screen for a minimum hold time after it
// releases, tracks live value changes of the owner and flags values wider than
// eight digits.
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      slave side of display_arbiter_if (requests in, grant/display out)
module display_arbiter #(
   parameter int unsigned      NUM_W       = 39,
   parameter int unsigned      MODE_W      = 2,
   parameter int unsigned      HOLD_CYCLES = 50_000_000,
   parameter logic [NUM_W-1:0] MAX_VAL     = NUM_W'(99_999_999)
) (
   input logic               clock,
   input logic               reset_n,
   display_arbiter_if.slave  bus
);

   localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StShow, StArb} state_e;

   state_e            state;
   logic [1:0]        owner;
   logic [CNT_W-1:0]  hold_cnt;
   logic [2:0]        grant;
   logic              disp_valid;
   logic [NUM_W-1:0]  disp_number;
   logic [MODE_W-1:0] disp_mode;
   logic              disp_ovf;

   logic [1:0]        winner;
   logic              any_req;
   logic              owner_req;
   logic [NUM_W-1:0]  sel_num;
   logic [MODE_W-1:0] sel_mode;

   // Highest set request index; 0 when nothing is requested (qualify with any_req).
   always_comb begin
      winner = 2'd0;
      if (bus.req[2]) begin
         winner = 2'd2;
      end else if (bus.req[1]) begin
         winner = 2'd1;
      end
   end

   assign any_req   = |bus.req;
   assign owner_req = bus.req[owner];

   always_comb begin
      sel_num  = bus.num0;
      sel_mode = bus.mode0;
      case (owner)
         2'd1: begin
            sel_num  = bus.num1;
            sel_mode = bus.mode1;
         end
         2'd2: begin
            sel_num  = bus.num2;
            sel_mode = bus.mode2;
         end
         default: begin
            sel_num  = bus.num0;
            sel_mode = bus.mode0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= StIdle;
         owner       <= 2'd0;
         hold_cnt    <= '0;
         grant       <= 3'b000;
         disp_valid  <= 1'b0;
         disp_number <= '0;
         disp_mode   <= '0;
         disp_ovf    <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (any_req) begin
                  owner <= winner;
                  state <= StLoad;
               end
            end
            StLoad: begin
               // Previous display stays up during this cycle; the new owner appears at its end.
               disp_number <= sel_num;
               disp_mode   <= sel_mode;
               disp_ovf    <= (sel_num > MAX_VAL);
               grant       <= 3'b001 << owner;
               disp_valid  <= 1'b1;
               hold_cnt    <= '0;
               state       <= StShow;
            end
            StShow: begin
               if (any_req && (winner > owner)) begin
                  // Higher priority preempts regardless of the hold counter.
                  owner <= winner;
                  state <= StLoad;
               end else if (owner_req) begin
                  // Live tracking; counter frozen so a resumed owner keeps its progress.
                  disp_number <= sel_num;
                  disp_mode   <= sel_mode;
                  disp_ovf    <= (sel_num > MAX_VAL);
               end else if (hold_cnt == CNT_LAST) begin
                  state <= StArb;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            StArb: begin
               if (any_req) begin
                  owner <= winner;
                  state <= StLoad;
               end else begin
                  grant       <= 3'b000;
                  disp_valid  <= 1'b0;
                  disp_number <= '0;
                  disp_mode   <= '0;
                  disp_ovf    <= 1'b0;
                  state       <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign bus.grant       = grant;
   assign bus.disp_valid  = disp_valid;
   assign bus.disp_number = disp_number;
   assign bus.disp_mode   = disp_mode;
   assign bus.disp_ovf    = disp_ovf;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with HOLD_CYCLES = 8.
module tb_display_arbiter;

   localparam int unsigned NUM_W  = 39;
   localparam int unsigned MODE_W = 2;
   localparam int unsigned HOLD   = 8;

   logic clock;
   logic reset_n;

   int n_cmp;
   int n_err;

   display_arbiter_if #(.NUM_W(NUM_W), .MODE_W(MODE_W)) bus ();

   display_arbiter #(
      .NUM_W       (NUM_W),
      .MODE_W      (MODE_W),
      .HOLD_CYCLES (HOLD),
      .MAX_VAL     (NUM_W'(99_999_999))
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
      end
      #1;
   endtask

   task automatic check_out(input string tag, input logic [2:0] g, input logic v,
                            input logic [NUM_W-1:0] num, input logic [MODE_W-1:0] md,
                            input logic ovf);
      check_eq({tag, ".grant"}, 64'(bus.grant), 64'(g));
      check_eq({tag, ".valid"}, 64'(bus.disp_valid), 64'(v));
      check_eq({tag, ".number"}, 64'(bus.disp_number), 64'(num));
      check_eq({tag, ".mode"}, 64'(bus.disp_mode), 64'(md));
      check_eq({tag, ".ovf"}, 64'(bus.disp_ovf), 64'(ovf));
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      reset_n = 1'b0;
      bus.req   = 3'b000;
      bus.num0  = '0;
      bus.num1  = '0;
      bus.num2  = '0;
      bus.mode0 = '0;
      bus.mode1 = '0;
      bus.mode2 = '0;
      #12;
      reset_n = 1'b1;
      tick(2);
      check_out("reset", 3'b000, 1'b0, '0, '0, 1'b0);

      // Single requester, 2-edge latency then live tracking.
      bus.req   = 3'b001;
      bus.num0  = 39'd1234;
      bus.mode0 = 2'd1;
      tick(1);
      check_eq("lat1.grant", 64'(bus.grant), 64'h0);
      tick(1);
      check_out("own0", 3'b001, 1'b1, 39'd1234, 2'd1, 1'b0);
      bus.num0 = 39'd1235;
      tick(1);
      check_eq("live0.number", 64'(bus.disp_number), 64'd1235);

      // Preemption by requester 2; old display kept during LOAD.
      bus.req   = 3'b101;
      bus.num2  = 39'd42;
      bus.mode2 = 2'd2;
      tick(1);
      check_out("pre2.load", 3'b001, 1'b1, 39'd1235, 2'd1, 1'b0);
      tick(1);
      check_out("pre2", 3'b100, 1'b1, 39'd42, 2'd2, 1'b0);

      // Requester 2 releases with 1 and 0 waiting: 8 hold + ARB + LOAD.
      bus.num1  = 39'd77;
      bus.mode1 = 2'd3;
      bus.num2  = 39'd43;
      bus.req   = 3'b011;
      tick(9);
      check_out("hold2", 3'b100, 1'b1, 39'd42, 2'd2, 1'b0);
      tick(1);
      check_out("own1", 3'b010, 1'b1, 39'd77, 2'd3, 1'b0);

      // Owner 1 drops with 0 waiting: lower never preempts early.
      bus.req = 3'b001;
      tick(9);
      check_eq("hold1.grant", 64'(bus.grant), 64'b010);
      tick(1);
      check_out("own0b", 3'b001, 1'b1, 39'd1235, 2'd1, 1'b0);

      // Back to owner 1, release for 3 cycles, resume, then release again.
      bus.req = 3'b011;
      tick(2);
      check_eq("own1b.grant", 64'(bus.grant), 64'b010);
      bus.req = 3'b001;
      tick(3);
      bus.req  = 3'b011;
      bus.num1 = 39'd88;
      tick(4);
      check_eq("resume.grant", 64'(bus.grant), 64'b010);
      check_eq("resume.number", 64'(bus.disp_number), 64'd88);
      bus.req = 3'b001;
      // Counter resumes from 3: 5 edges to ARB, then ARB and LOAD.
      tick(6);
      check_eq("resume.hold", 64'(bus.grant), 64'b010);
      tick(1);
      check_eq("resume.handover", 64'(bus.grant), 64'b001);

      // Overflow flag boundaries.
      bus.num0 = 39'd100_000_000;
      tick(1);
      check_eq("ovf.above", 64'(bus.disp_ovf), 64'd1);
      bus.num0 = 39'd99_999_999;
      tick(1);
      check_eq("ovf.max", 64'(bus.disp_ovf), 64'd0);
      check_eq("ovf.max.number", 64'(bus.disp_number), 64'd99_999_999);
      bus.num0 = {NUM_W{1'b1}};
      tick(1);
      check_eq("ovf.allones", 64'(bus.disp_ovf), 64'd1);

      // All requests drop: hold then ARB clears everything.
      bus.req = 3'b000;
      tick(8);
      check_eq("drop.hold.grant", 64'(bus.grant), 64'b001);
      check_eq("drop.hold.valid", 64'(bus.disp_valid), 64'd1);
      tick(1);
      check_out("idle", 3'b000, 1'b0, '0, '0, 1'b0);
      tick(3);
      check_eq("idle.stay", 64'(bus.grant), 64'h0);

      // Owner drops while a higher request rises in the same cycle.
      bus.num0 = 39'd5;
      bus.req  = 3'b001;
      tick(2);
      check_eq("simul.own0", 64'(bus.grant), 64'b001);
      bus.num2 = 39'd9;
      bus.req  = 3'b100;
      tick(1);
      check_eq("simul.load", 64'(bus.grant), 64'b001);
      tick(1);
      check_out("simul.own2", 3'b100, 1'b1, 39'd9, 2'd2, 1'b0);

      // Asynchronous reset mid-SHOW, checked between edges.
      #2;
      reset_n = 1'b0;
      #1;
      check_out("async_rst", 3'b000, 1'b0, '0, '0, 1'b0);
      #2;
      reset_n = 1'b1;
      tick(1);
      check_eq("post_rst.lat1", 64'(bus.grant), 64'h0);
      tick(1);
      check_out("post_rst", 3'b100, 1'b1, 39'd9, 2'd2, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
